// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage of the SCPU core. Holds the PC and issues one
// request at a time to instruction memory. Returned words go into a small
// FIFO, and the FIFO head is presented to decode. A taken branch from execute
// flushes the FIFO and kills any response that is still in flight.
//
// Optional feature (macro FETCH_PERF_EN):
//   When defined, two 32-bit saturating performance counters are added as
//   output ports. perf_fetch_cnt counts pushes. perf_drop_cnt counts
//   discarded responses.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   imem_req       fetch request valid
//   imem_addr      fetch address (always the PC register)
//   imem_gnt       memory accepts the request this cycle
//   imem_rvalid    read data valid
//   imem_rdata     instruction word from memory
//   inst_valid     FIFO head is valid
//   inst_ready     decode consumes the head this cycle
//   inst           head instruction (0 when empty)
//   inst_pc        PC of the head instruction (0 when empty)
//   opcode         inst[6:0] (0 when empty)
//   redirect_valid taken branch or jump from execute
//   redirect_pc    redirect target
//   perf_fetch_cnt pushes into the FIFO          (FETCH_PERF_EN only)
//   perf_drop_cnt  discarded memory responses    (FETCH_PERF_EN only)
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // IDLE may issue. WAIT expects a live response.
  // DROP expects a response that must be thrown away.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_reqPc;

  logic [XLEN-1:0] r_fifoInst [FIFO_DEPTH];
  logic [XLEN-1:0] r_fifoPc   [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic            w_instValid;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_redirPc;
  logic [XLEN-1:0] w_headInst;

  // Masking with ~3 keeps every bit of redirect_pc in use. Misaligned
  // targets are forced onto a word boundary.
  assign w_redirPc   = redirect_pc & ~XLEN'(3);

  assign w_instValid = (r_count != '0);

  // Redirect suppresses the request. This prevents a grant from racing
  // with the PC update in the same cycle.
  assign imem_req    = (r_state == ST_IDLE) && (r_count < DEPTH_C) && !redirect_valid;
  assign imem_addr   = r_pc;
  assign w_issue     = imem_req && imem_gnt;

  // A redirect blocks both push and pop. The FIFO is flushed instead.
  assign w_push      = (r_state == ST_WAIT) && imem_rvalid && !redirect_valid;
  assign w_pop       = w_instValid && inst_ready && !redirect_valid;

  assign w_headInst  = w_instValid ? r_fifoInst[r_rdPtr] : '0;
  assign inst_valid  = w_instValid;
  assign inst        = w_headInst;
  assign inst_pc     = w_instValid ? r_fifoPc[r_rdPtr] : '0;
  assign opcode      = w_headInst[6:0];

  // PC and request state. A redirect overrides everything else. If a
  // response lands in the same cycle as the redirect, that response is the
  // one being killed, so there is nothing left to wait for and the stage
  // returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_reqPc <= '0;
    end else if (redirect_valid) begin
      r_pc <= w_redirPc;
      case (r_state)
        ST_WAIT: r_state <= imem_rvalid ? ST_IDLE : ST_DROP;
        ST_DROP: r_state <= imem_rvalid ? ST_IDLE : ST_DROP;
        default: r_state <= ST_IDLE;
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_reqPc <= r_pc;
            r_pc    <= r_pc + XLEN'(4);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) r_state <= ST_IDLE;
        end
        ST_DROP: begin
          if (imem_rvalid) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping. Pointers wrap naturally because the depth is a
  // power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || redirect_valid) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // FIFO storage needs no reset. Entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoInst[r_wrPtr] <= imem_rdata;
      r_fifoPc[r_wrPtr]   <= r_reqPc;
    end
  end

`ifdef FETCH_PERF_EN
  logic        w_discard;
  logic [31:0] r_perfFetch;
  logic [31:0] r_perfDrop;

  assign w_discard = imem_rvalid &&
                     ((r_state == ST_DROP) || ((r_state == ST_WAIT) && redirect_valid));

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perfFetch <= '0;
      r_perfDrop  <= '0;
    end else begin
      if (w_push && (r_perfFetch != '1))   r_perfFetch <= r_perfFetch + 32'd1;
      if (w_discard && (r_perfDrop != '1)) r_perfDrop  <= r_perfDrop + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perfFetch;
  assign perf_drop_cnt  = r_perfDrop;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
module tb_inst_fetch;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  inst_fetch #(
    .XLEN(XLEN),
    .RESET_PC(RESET_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .opcode(opcode),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory content: address 0 holds addi x1,x0,5. Every other word encodes
  // its own address so that mis-ordered data is visible.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[24:0], 7'b0110011};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder. It accepts a grant while gntEn is set, then answers
  // rspLat cycles later. The responder ignores reset, so a response to an
  // abandoned request still arrives.
  bit          gntEn  = 1'b0;
  int          rspLat = 1;
  int          memCnt = 0;
  logic [31:0] memAddr;

  task automatic tick();
    bit          issued;
    logic [31:0] a;
    @(negedge clk);
    issued = rst_n && imem_req && imem_gnt;
    a      = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (issued) begin
      memCnt  = rspLat;
      memAddr = a;
    end
    if (memCnt > 0) begin
      memCnt--;
      if (memCnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memWord(memAddr);
      end
    end
    imem_gnt = gntEn;
  endtask

  task automatic applyStimulus(input logic rdv, input logic [31:0] rpc, input logic rdy, input int n);
    for (int i = 0; i < n; i++) begin
      redirect_valid = rdv;
      redirect_pc    = rpc;
      inst_ready     = rdy;
      tick();
    end
  endtask

  // Reference model: a queue of fetched {pc, word} pairs plus a record of
  // the one outstanding request (none / live / killed).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      mQ[$];
  int          mOut = 0;
  logic [31:0] mPc;
  logic [31:0] mOutPc;
  bit          armed = 1'b0;
  int          mFetch = 0;
  int          mDrop  = 0;

  initial forever begin
    bit req;
    bit pop;
    @(posedge clk);
    if (!rst_n) begin
      armed  = 1'b1;
      mPc    = RESET_PC;
      mQ.delete();
      mOut   = 0;
      mFetch = 0;
      mDrop  = 0;
    end else if (armed) begin
      req = (mOut == 0) && (mQ.size() < DEPTH) && !redirect_valid;
      if (redirect_valid) begin
        mQ.delete();
        mPc = redirect_pc & 32'hFFFF_FFFC;
        if (mOut != 0 && imem_rvalid) begin
          mOut = 0;
          mDrop++;
        end else if (mOut == 1) begin
          mOut = 2;
        end
      end else begin
        pop = (mQ.size() > 0) && inst_ready;
        if (pop) void'(mQ.pop_front());
        if (mOut == 1 && imem_rvalid) begin
          mQ.push_back({mOutPc, imem_rdata});
          mOut = 0;
          mFetch++;
        end else if (mOut == 2 && imem_rvalid) begin
          mOut = 0;
          mDrop++;
        end else if (mOut == 0 && req && imem_gnt) begin
          mOutPc = mPc;
          mPc    = mPc + 32'd4;
          mOut   = 1;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, on the falling edge.
  initial forever begin
    entry_t h;
    bit     v;
    @(negedge clk);
    if (armed) begin
      v = (mQ.size() != 0);
      h = v ? mQ[0] : '0;
      checkOutput("imem_req", {31'b0, imem_req},
                  {31'b0, (mOut == 0) && (mQ.size() < DEPTH) && !redirect_valid});
      checkOutput("imem_addr", imem_addr, mPc);
      checkOutput("inst_valid", {31'b0, inst_valid}, {31'b0, v});
      checkOutput("inst", inst, h.word);
      checkOutput("inst_pc", inst_pc, h.pc);
      checkOutput("opcode", {25'b0, opcode}, {25'b0, h.word[6:0]});
`ifdef FETCH_PERF_EN
      checkOutput("perf_fetch_cnt", perf_fetch_cnt, 32'(mFetch));
      checkOutput("perf_drop_cnt", perf_drop_cnt, 32'(mDrop));
`endif
    end
  end

  task automatic doReset();
    rst_n  = 1'b0;
    memCnt = 0;
    applyStimulus(1'b0, 32'h0, 1'b0, 2);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Basic fetch with a 1-cycle memory response.
    gntEn  = 1'b1;
    rspLat = 1;
    doReset();
    #1;
    checkOutput("t1_req_after_reset", {31'b0, imem_req}, 32'd1);
    checkOutput("t1_addr_after_reset", imem_addr, 32'h0);
    checkOutput("t1_valid_after_reset", {31'b0, inst_valid}, 32'd0);
    checkOutput("t1_inst_after_reset", inst, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 2);
    #1;
    checkOutput("t1_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("t1_inst", inst, 32'h0050_0093);
    checkOutput("t1_inst_pc", inst_pc, 32'h0);
    checkOutput("t1_opcode", {25'b0, opcode}, 32'h13);
    checkOutput("t1_next_addr", imem_addr, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b1, 3);

    // Back-pressure: the FIFO fills with two entries, then requests stop.
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 6);
    #1;
    checkOutput("t2_full_req", {31'b0, imem_req}, 32'd0);
    checkOutput("t2_full_addr", imem_addr, 32'h8);
    checkOutput("t2_head_pc", inst_pc, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1);
    #1;
    checkOutput("t2_pop_req", {31'b0, imem_req}, 32'd1);
    checkOutput("t2_pop_addr", imem_addr, 32'h8);
    checkOutput("t2_pop_head_pc", inst_pc, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b0, 3);
    #1;
    checkOutput("t2_refill_req", {31'b0, imem_req}, 32'd0);
    checkOutput("t2_refill_addr", imem_addr, 32'hC);

    // Redirect while a slow response is outstanding.
    doReset();
    rspLat = 1;
    applyStimulus(1'b0, 32'h0, 1'b0, 2);
    rspLat = 3;
    applyStimulus(1'b0, 32'h0, 1'b0, 1);
    applyStimulus(1'b1, 32'h100, 1'b0, 1);
    #1;
    checkOutput("t3_flushed", {31'b0, inst_valid}, 32'd0);
    checkOutput("t3_drop_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 2);
    #1;
    checkOutput("t3_after_drop_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("t3_after_drop_req", {31'b0, imem_req}, 32'd1);
    checkOutput("t3_after_drop_addr", imem_addr, 32'h100);
`ifdef FETCH_PERF_EN
    checkOutput("t3_perf_drop", perf_drop_cnt, 32'd1);
    checkOutput("t3_perf_fetch", perf_fetch_cnt, 32'd1);
`endif
    applyStimulus(1'b0, 32'h0, 1'b1, 6);

    // Redirect coincident with rvalid and inst_ready, to a misaligned target.
    doReset();
    rspLat = 1;
    applyStimulus(1'b0, 32'h0, 1'b0, 3);
    #1;
    checkOutput("t4_pre_valid", {31'b0, inst_valid}, 32'd1);
    applyStimulus(1'b1, 32'h203, 1'b1, 1);
    redirect_valid = 1'b0;
    #1;
    checkOutput("t4_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("t4_req", {31'b0, imem_req}, 32'd1);
    checkOutput("t4_addr", imem_addr, 32'h200);
    applyStimulus(1'b0, 32'h0, 1'b1, 4);

    // Reset while waiting, followed by a stray response.
    doReset();
    rspLat = 3;
    applyStimulus(1'b0, 32'h0, 1'b0, 1);
    rst_n = 1'b0;
    gntEn = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 2);
    #1;
    checkOutput("t6_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("t6_addr", imem_addr, RESET_PC);
    checkOutput("t6_req", {31'b0, imem_req}, 32'd1);
    gntEn  = 1'b1;
    rspLat = 1;
    applyStimulus(1'b0, 32'h0, 1'b1, 4);

    // Mixed traffic: varying latency, grant gaps, ready gaps and redirects.
    doReset();
    for (int i = 0; i < 80; i++) begin
      rspLat = 1 + (i % 3);
      gntEn  = ((i % 5) != 3);
      applyStimulus(((i % 13) == 7), 32'h400 + 32'(i * 8) + 32'(i % 4), ((i % 3) != 0), 1);
    end
    gntEn = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 8);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
